// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared address map and seven-segment glyph table
package mmio_pkg;

  localparam logic [31:0] ADDR_DIG   = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_TDIV  = 32'hFFFF_F024;
  localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN   = 32'hFFFF_F078;

  // Active-low {DP,G,F,E,D,C,B,A}; entry n is the glyph for hex digit n.
  localparam logic [15:0][7:0] SEG_GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    return SEG_GLYPH[nib];
  endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// rtl/mmio_bridge_if.sv - CPU data-bus signal bundle
interface mmio_bridge_if;
  logic [31:0] Bus_addr;
  logic        Bus_we;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport master (output Bus_addr, Bus_we, Bus_wdata, input Bus_rdata);
  modport slave  (input Bus_addr, Bus_we, Bus_wdata, output Bus_rdata);
endinterface

// File: rtl/mmio_bridge_seg_scan.sv
// rtl/mmio_bridge_seg_scan.sv - eight-digit seven-segment display scanner
module seg_scan
  import mmio_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] dig_i,
  output logic [7:0]  dig_en_o,
  output logic [7:0]  dig_seg_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] scan_q, scan_d;
  logic [2:0]    idx_q, idx_d;
  logic          wrap;

  // Dwell counter; the digit index advances only when the dwell wraps.
  always_comb begin
    wrap   = (scan_q == CW'(SCAN_DIV - 1));
    scan_d = wrap ? '0 : scan_q + CW'(1);
    idx_d  = wrap ? idx_q + 3'd1 : idx_q;
  end

  // Scan state registers.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
    end
  end

  // Enable the current digit and show its nibble; DP stays dark.
  always_comb begin
    dig_en_o  = ~(8'd1 << idx_q);
    dig_seg_o = seg_decode(dig_i[{idx_q, 2'b00} +: 4]);
  end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - CPU data-bus responder for DRAM, display, LEDs, inputs, timer
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int SCAN_DIV = 20000,
  parameter int DRAM_AW  = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  mmio_bridge_if.slave       bus,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         button,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  logic [31:0] dig_q, dig_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] tdiv_q, tdiv_d;
  logic [31:0] presc_q, presc_d;
  logic [23:0] led_q, led_d;
  logic [23:0] sw_meta_q, sw_sync_q;
  logic [4:0]  btn_meta_q, btn_sync_q;

  logic sel_dig, sel_timer, sel_tdiv, sel_led, sel_sw, sel_btn, sel_periph;
  logic tick;

  // Full 32-bit address decode; anything unmatched belongs to DRAM.
  always_comb begin
    sel_dig    = (bus.Bus_addr == ADDR_DIG);
    sel_timer  = (bus.Bus_addr == ADDR_TIMER);
    sel_tdiv   = (bus.Bus_addr == ADDR_TDIV);
    sel_led    = (bus.Bus_addr == ADDR_LED);
    sel_sw     = (bus.Bus_addr == ADDR_SW);
    sel_btn    = (bus.Bus_addr == ADDR_BTN);
    sel_periph = sel_dig | sel_timer | sel_tdiv | sel_led | sel_sw | sel_btn;
    dram_addr  = bus.Bus_addr[DRAM_AW+1:2];
    dram_we    = bus.Bus_we & ~sel_periph;
    dram_wdata = bus.Bus_wdata;
  end

  // Combinational read mux so the CPU sees data in the same cycle.
  always_comb begin
    if (sel_dig)        bus.Bus_rdata = dig_q;
    else if (sel_timer) bus.Bus_rdata = timer_q;
    else if (sel_tdiv)  bus.Bus_rdata = tdiv_q;
    else if (sel_led)   bus.Bus_rdata = {8'b0, led_q};
    else if (sel_sw)    bus.Bus_rdata = {8'b0, sw_sync_q};
    else if (sel_btn)   bus.Bus_rdata = {27'b0, btn_sync_q};
    else                bus.Bus_rdata = dram_rdata;
  end

  // Register writes and timer: a TIMER write overrides a same-cycle increment.
  always_comb begin
    tick    = (tdiv_q != 32'd0) && (presc_q == tdiv_q - 32'd1);
    dig_d   = dig_q;
    led_d   = led_q;
    tdiv_d  = tdiv_q;
    timer_d = tick ? timer_q + 32'd1 : timer_q;
    presc_d = (tdiv_q == 32'd0 || tick) ? 32'd0 : presc_q + 32'd1;
    if (bus.Bus_we) begin
      if (sel_dig)   dig_d   = bus.Bus_wdata;
      if (sel_led)   led_d   = bus.Bus_wdata[23:0];
      if (sel_timer) timer_d = bus.Bus_wdata;
      if (sel_tdiv) begin
        tdiv_d  = bus.Bus_wdata;
        presc_d = 32'd0;
      end
    end
  end

  // State registers plus two-flop synchronisers for the board inputs.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      dig_q      <= '0;
      timer_q    <= '0;
      tdiv_q     <= '0;
      presc_q    <= '0;
      led_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      dig_q      <= dig_d;
      timer_q    <= timer_d;
      tdiv_q     <= tdiv_d;
      presc_q    <= presc_d;
      led_q      <= led_d;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= button;
      btn_sync_q <= btn_meta_q;
    end
  end

  assign led = led_q;

  seg_scan #(.SCAN_DIV(SCAN_DIV)) u_seg_scan (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .dig_i     (dig_q),
    .dig_en_o  (dig_en),
    .dig_seg_o (dig_seg)
  );

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - self-checking bench for mmio_bridge
module tb_mmio_bridge;

  localparam int SD = 4;
  localparam logic [31:0] A_DIG = 32'hFFFF_F000, A_TIMER = 32'hFFFF_F020,
                          A_TDIV = 32'hFFFF_F024, A_LED = 32'hFFFF_F060,
                          A_SW = 32'hFFFF_F070, A_BTN = 32'hFFFF_F078;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  mmio_bridge_if bus();
  logic [13:0] dram_addr;
  logic        dram_we;
  logic [31:0] dram_wdata, dram_rdata;
  logic [23:0] sw = '0;
  logic [4:0]  button = '0;
  logic [23:0] led;
  logic [7:0]  dig_en, dig_seg;

  mmio_bridge #(.SCAN_DIV(SD), .DRAM_AW(14)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus),
    .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata), .sw(sw), .button(button), .led(led),
    .dig_en(dig_en), .dig_seg(dig_seg)
  );

  // Stand-in DRAM: read data is a recognisable function of the word address.
  assign dram_rdata = 32'hD000_0000 | {18'b0, dram_addr};

  int passed = 0, total = 0, fails = 0;
  int ecount = 0;

  // Rising edges seen since reset was last released.
  always @(posedge cpu_clk or negedge cpu_rst)
    if (!cpu_rst) ecount <= 0;
    else ecount <= ecount + 1;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic bit is_periph(input logic [31:0] a);
    return a inside {A_DIG, A_TIMER, A_TDIV, A_LED, A_SW, A_BTN};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] wa;
    bus.Bus_addr = a; bus.Bus_wdata = d; bus.Bus_we = 1'b1;
    #1;
    wa = (a >> 2) & 32'h3FFF;
    check("dram_we", {31'b0, dram_we}, {31'b0, !is_periph(a)});
    check("dram_addr", {18'b0, dram_addr}, wa);
    check("dram_wdata", dram_wdata, d);
    step();
    bus.Bus_we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.Bus_addr = a;
    #1;
    check(tag, bus.Bus_rdata, exp);
  endtask

  task automatic check_scan(input logic [31:0] dig);
    int idx;
    logic [31:0] sh;
    idx = (ecount / SD) % 8;
    sh = dig >> (4 * idx);
    check("dig_en", {24'b0, dig_en}, {24'b0, ~(8'd1 << idx)});
    check("dig_seg", {24'b0, dig_seg}, {24'b0, glyph(sh[3:0])});
  endtask

  initial begin
    logic [31:0] d, a, t0, exp_dig;
    logic [23:0] sw_old, sw_new;
    logic [4:0]  bt_old, bt_new;
    int n;

    bus.Bus_addr = '0; bus.Bus_we = 1'b0; bus.Bus_wdata = '0;
    #12 cpu_rst = 1'b1;

    // Reset state.
    check("rst_led", {8'b0, led}, 32'h0);
    check("rst_dig_en", {24'b0, dig_en}, 32'hFE);
    check("rst_dig_seg", {24'b0, dig_seg}, 32'hC0);
    read_check("rst_timer", A_TIMER, 32'h0);
    for (int i = 0; i < 100; i++) step();
    read_check("timer_idle", A_TIMER, 32'h0);
    check_scan(32'h0);

    // LED register, directed then random.
    bus_write(A_LED, 32'h00AB_CDEF);
    check("led_pin", {8'b0, led}, 32'h00AB_CDEF);
    read_check("led_rd", A_LED, 32'h00AB_CDEF);
    check("led_rd_dram_we", {31'b0, dram_we}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      bus_write(A_LED, d);
      check("led_rand_pin", {8'b0, led}, {8'b0, d[23:0]});
      read_check("led_rand_rd", A_LED, {8'b0, d[23:0]});
    end

    // DRAM path, including addresses adjacent to peripherals.
    bus_write(32'h0000_0010, 32'h1234_5678);
    read_check("dram_rd", 32'h0000_0010, 32'hD000_0004);
    bus_write(32'hFFFF_F004, 32'hCAFE_0001);
    bus_write(32'hFFFF_F062, 32'hCAFE_0002);
    read_check("near_led_rd", 32'hFFFF_F062, 32'hD000_0000 | ((32'hFFFF_F062 >> 2) & 32'h3FFF));
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      if (is_periph(a)) a = 32'h0000_0100;
      bus_write(a, $urandom);
      read_check("dram_rand_rd", a, 32'hD000_0000 | ((a >> 2) & 32'h3FFF));
    end

    // Timer: TDIV=3 from a stopped timer counts once every 3 edges.
    bus_write(A_TDIV, 32'd3);
    read_check("tdiv_rd", A_TDIV, 32'd3);
    for (int k = 1; k <= 12; k++) begin
      step();
      read_check("timer_div3", A_TIMER, k / 3);
    end
    step(); step();
    bus_write(A_TIMER, 32'd100);
    read_check("timer_wr_wins", A_TIMER, 32'd100);
    step(); step();
    read_check("timer_hold", A_TIMER, 32'd100);
    step();
    read_check("timer_after_wr", A_TIMER, 32'd101);

    // Stopping, wrap modulo 2^32 with TDIV=1, then a random divider.
    bus_write(A_TDIV, 32'd0);
    read_check("timer_stop0", A_TIMER, 32'd101);
    for (int i = 0; i < 5; i++) step();
    read_check("timer_stopped", A_TIMER, 32'd101);
    bus_write(A_TIMER, 32'hFFFF_FFFE);
    bus_write(A_TDIV, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      read_check("timer_wrap", A_TIMER, 32'hFFFF_FFFE + k);
    end
    bus_write(A_TDIV, 32'd0);
    bus.Bus_addr = A_TIMER; #1; t0 = bus.Bus_rdata;
    n = $urandom_range(2, 6);
    bus_write(A_TDIV, n);
    for (int k = 1; k <= 3 * n + 2; k++) begin
      step();
      read_check("timer_rand_div", A_TIMER, t0 + k / n);
    end
    bus_write(A_TDIV, 32'd0);

    // Display scan with a directed and a random value.
    exp_dig = 32'h0000_00A5;
    bus_write(A_DIG, exp_dig);
    read_check("dig_rd", A_DIG, exp_dig);
    for (int i = 0; i < 40; i++) begin
      check_scan(exp_dig);
      step();
    end
    exp_dig = $urandom;
    bus_write(A_DIG, exp_dig);
    for (int i = 0; i < 36; i++) begin
      check_scan(exp_dig);
      step();
    end

    // Switch and button synchronisers.
    sw_old = 24'h0; sw_new = 24'h80_0001;
    for (int i = 0; i < 3; i++) begin
      #2 sw = sw_new;
      step();
      read_check("sw_one_edge", A_SW, {8'b0, sw_old});
      step();
      read_check("sw_two_edges", A_SW, {8'b0, sw_new});
      sw_old = sw_new;
      sw_new = $urandom;
    end
    bus_write(A_SW, 32'hFFFF_FFFF);
    read_check("sw_ro", A_SW, {8'b0, sw_old});
    bt_old = 5'h0;
    for (int i = 0; i < 3; i++) begin
      bt_new = 5'($urandom);
      #3 button = bt_new;
      step();
      read_check("btn_one_edge", A_BTN, {27'b0, bt_old});
      step();
      read_check("btn_two_edges", A_BTN, {27'b0, bt_new});
      bt_old = bt_new;
    end
    bus_write(A_BTN, 32'hFFFF_FFFF);
    read_check("btn_ro", A_BTN, {27'b0, bt_old});

    // Reset asserted mid-scan clears state at once; a write during reset is lost.
    for (int i = 0; i < 5; i++) step();
    #3 cpu_rst = 1'b0;
    #1;
    check("rst_mid_dig_en", {24'b0, dig_en}, 32'hFE);
    check("rst_mid_dig_seg", {24'b0, dig_seg}, 32'hC0);
    check("rst_mid_led", {8'b0, led}, 32'h0);
    read_check("rst_mid_sw", A_SW, 32'h0);
    bus.Bus_addr = A_LED; bus.Bus_wdata = 32'h00FF_FFFF; bus.Bus_we = 1'b1;
    step();
    bus.Bus_we = 1'b0;
    check("rst_write_lost", {8'b0, led}, 32'h0);
    #2 cpu_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_scan(32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
